// File: rtl/mat_pkg.sv
// Shared definitions for the multiply-adder-tree array and its feeder.
package mat_pkg;
    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int BIAS_W = 18;
    localparam int VEC_W  = LANES * DATA_W;

    // Index width that stays at least 1 bit so a single-group build still has a port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mat_feeder_addr_gen.sv
// Walks (pix, g) over the job and drives the activation/weight SRAM read addresses.
// Addresses are registered; tags describing the beat being issued are combinational
// from the same registers so they line up with the address.
module mat_feeder_addr_gen
    import mat_pkg::*;
#(
    parameter int CH_GROUPS = 4,
    parameter int PIX_W     = 12
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       launch,
    input  logic [PIX_W-1:0]                           num_pixels,
    output logic [PIX_W+clog2_min1(CH_GROUPS)-1:0]     act_addr,
    output logic [clog2_min1(CH_GROUPS)-1:0]           wgt_addr,
    output logic                                       issue_vld,
    output logic                                       issue_first,
    output logic                                       issue_last,
    output logic                                       issue_fin,
    output logic [PIX_W-1:0]                           issue_pix
);
    localparam int G_W = clog2_min1(CH_GROUPS);
    localparam logic [G_W-1:0] GMAX = G_W'(CH_GROUPS - 1);

    logic [PIX_W-1:0] last_pix;

    // wgt_addr doubles as the group counter g; pix*CH_GROUPS+g advances by one per beat.
    assign issue_first = issue_vld && (wgt_addr == '0);
    assign issue_last  = issue_vld && (wgt_addr == GMAX);
    assign issue_fin   = issue_last && (issue_pix == last_pix);

    // Counter walk: start at launch, stop (and zero the addresses) after the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_vld <= 1'b0;
            wgt_addr  <= '0;
            issue_pix <= '0;
            act_addr  <= '0;
            last_pix  <= '0;
        end else if (launch) begin
            issue_vld <= 1'b1;
            wgt_addr  <= '0;
            issue_pix <= '0;
            act_addr  <= '0;
            last_pix  <= num_pixels - 1'b1;
        end else if (issue_vld) begin
            if (issue_fin) begin
                issue_vld <= 1'b0;
                wgt_addr  <= '0;
                issue_pix <= '0;
                act_addr  <= '0;
            end else begin
                act_addr <= act_addr + 1'b1;
                if (wgt_addr == GMAX) begin
                    wgt_addr  <= '0;
                    issue_pix <= issue_pix + 1'b1;
                end else begin
                    wgt_addr <= wgt_addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mat_feeder.sv
// Sequencer feeding the M-filter multiply-adder-tree array: reads activations and
// weights, presents one beat per cycle with load on each pixel's first beat, and
// flags the cycle when out_filter holds a finished pixel.
module mat_feeder
    import mat_pkg::*;
#(
    parameter int M         = 8,
    parameter int CH_GROUPS = 4,
    parameter int PIX_W     = 12,
    parameter int PIPE_LAT  = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [PIX_W-1:0]                           num_pixels,
    input  logic [M-1:0][BIAS_W-1:0]                   bias_cfg,
    output logic [PIX_W+clog2_min1(CH_GROUPS)-1:0]     act_addr,
    input  logic [VEC_W-1:0]                           act_data,
    output logic [clog2_min1(CH_GROUPS)-1:0]           wgt_addr,
    input  logic [M-1:0][VEC_W-1:0]                    wgt_data,
    output logic [VEC_W-1:0]                           data_in,
    output logic [M-1:0][VEC_W-1:0]                    weight,
    output logic [M-1:0][BIAS_W-1:0]                   bias,
    output logic                                       load,
    output logic                                       out_capture,
    output logic [PIX_W-1:0]                           out_pix,
    output logic                                       busy,
    output logic                                       done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic             fin;
        logic [PIX_W-1:0] pix;
    } tag_t;

    typedef struct packed {
        logic             cap;
        logic             fin;
        logic [PIX_W-1:0] pix;
    } cap_t;

    state_t state;
    logic   launch;
    logic   issue_vld, issue_first, issue_last, issue_fin;
    logic [PIX_W-1:0] issue_pix;
    tag_t   issue_tag;
    tag_t   tag_pipe [1:2];
    cap_t   cap_pipe [1:PIPE_LAT];

    assign launch = (state == IDLE) && start && (num_pixels != '0);

    mat_feeder_addr_gen #(
        .CH_GROUPS (CH_GROUPS),
        .PIX_W     (PIX_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .launch      (launch),
        .num_pixels  (num_pixels),
        .act_addr    (act_addr),
        .wgt_addr    (wgt_addr),
        .issue_vld   (issue_vld),
        .issue_first (issue_first),
        .issue_last  (issue_last),
        .issue_fin   (issue_fin),
        .issue_pix   (issue_pix)
    );

    assign issue_tag = '{vld: issue_vld, first: issue_first, last: issue_last,
                         fin: issue_fin, pix: issue_pix};

    // Job control: IDLE -> RUN -> DRAIN -> DONE; an empty job spends one busy
    // cycle in DONE before the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bias  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_pixels != '0) begin
                            bias  <= bias_cfg;
                            state <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (issue_fin) state <= DRAIN;
                end
                DRAIN: begin
                    if (cap_pipe[PIPE_LAT].cap && cap_pipe[PIPE_LAT].fin) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat tags ride two stages alongside the SRAM read and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_pipe[1] <= '0;
            tag_pipe[2] <= '0;
        end else begin
            tag_pipe[1] <= issue_tag;
            tag_pipe[2] <= tag_pipe[1];
        end
    end

    // Output register: non-beat cycles present zeros so the accumulator is untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_in <= '0;
            weight  <= '0;
        end else begin
            data_in <= tag_pipe[1].vld ? act_data : '0;
            weight  <= tag_pipe[1].vld ? wgt_data : '0;
        end
    end

    assign load = tag_pipe[2].vld && tag_pipe[2].first;

    // Delay each pixel's last beat by the array latency to time the capture strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= PIPE_LAT; i++) cap_pipe[i] <= '0;
        end else begin
            cap_pipe[1].cap <= tag_pipe[2].vld && tag_pipe[2].last;
            cap_pipe[1].fin <= tag_pipe[2].vld && tag_pipe[2].fin;
            cap_pipe[1].pix <= (tag_pipe[2].vld && tag_pipe[2].last) ? tag_pipe[2].pix : '0;
            for (int i = 2; i <= PIPE_LAT; i++) cap_pipe[i] <= cap_pipe[i-1];
        end
    end

    assign out_capture = cap_pipe[PIPE_LAT].cap;
    assign out_pix     = cap_pipe[PIPE_LAT].pix;
endmodule
